// File: rtl/pe_ws_mac.sv
`default_nettype none
// ============================================================================
// Module   : pe_ws_mac
// Purpose  : Weight-stationary MAC processing element for the systolic CNN
//            array. It has signed DATA_W operands, a saturating ACC_W
//            partial sum and a shadow/active weight pair. The shadow/active
//            pair lets the next layer's weights load while the current layer
//            computes. A 2-stage valid-tagged pipeline carries the mode, and
//            a registered feature output forwards the activation to the
//            neighbouring PE.
// Ports    : clk_in            - clock, rising edge
//            nrst_in           - synchronous active-low reset
//            weight_load_in    - shadow weight <- weight_in
//            weight_in         - signed weight data
//            weight_swap_in    - active weight <- shadow weight
//            valid_in          - sample present on feature/psum/mode inputs
//            mode_in           - 00 MAC, 01 BYPASS, 10 EMIT_W, 11 MUL_ONLY
//            feature_in        - signed activation
//            partial_sum_in    - signed upstream partial sum
//            feature_out       - feature_in delayed one cycle
//            feature_valid_out - valid_in delayed one cycle
//            partial_sum_out   - signed result (held while valid_out=0)
//            valid_out         - new result this cycle (latency 2)
//            ovf_out           - result was saturated, qualified by valid_out
// Revision : 1.0 - initial release
// ============================================================================
module pe_ws_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     clk_in,
    input  logic                     nrst_in,
    input  logic                     weight_load_in,
    input  logic signed [DATA_W-1:0] weight_in,
    input  logic                     weight_swap_in,
    input  logic                     valid_in,
    input  logic [1:0]               mode_in,
    input  logic signed [DATA_W-1:0] feature_in,
    input  logic signed [ACC_W-1:0]  partial_sum_in,
    output logic signed [DATA_W-1:0] feature_out,
    output logic                     feature_valid_out,
    output logic signed [ACC_W-1:0]  partial_sum_out,
    output logic                     valid_out,
    output logic                     ovf_out
);

    localparam int         c_PROD_W    = 2 * DATA_W;
    localparam int         c_SUM_W     = ACC_W + 1;
    localparam logic [1:0] c_MODE_MAC  = 2'b00;
    localparam logic [1:0] c_MODE_BYP  = 2'b01;
    localparam logic [1:0] c_MODE_EMIT = 2'b10;
    localparam logic [1:0] c_MODE_MUL  = 2'b11;
    localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // The accumulator must be able to hold a full product.
    if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
        $error("pe_ws_mac: ACC_W must be at least 2*DATA_W");
    end

    // ------------------------------------------------------------------
    // Weight double buffer
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] r_weight_shadow;
    logic signed [DATA_W-1:0] r_weight_active;

    // With load and swap together, active takes the pre-edge shadow value
    // because both are non-blocking updates of the same edge.
    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            r_weight_shadow <= '0;
            r_weight_active <= '0;
        end else begin
            if (weight_load_in) r_weight_shadow <= weight_in;
            if (weight_swap_in) r_weight_active <= r_weight_shadow;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: multiply with the pre-swap active weight
    // ------------------------------------------------------------------
    logic signed [c_PROD_W-1:0] w_product;
    logic        [c_PROD_W-1:0] r_s1_product;
    logic        [ACC_W-1:0]    r_s1_psum;
    logic        [1:0]          r_s1_mode;
    logic        [DATA_W-1:0]   r_s1_weight;
    logic                       r_s1_valid;

    assign w_product = r_weight_active * feature_in;

    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            r_s1_product <= '0;
            r_s1_psum    <= '0;
            r_s1_mode    <= '0;
            r_s1_weight  <= '0;
            r_s1_valid   <= 1'b0;
        end else begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_s1_product <= w_product;
                r_s1_psum    <= partial_sum_in;
                r_s1_mode    <= mode_in;
                r_s1_weight  <= r_weight_active;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: mode select and saturation at ACC_W+1 bits
    // ------------------------------------------------------------------
    logic [c_SUM_W-1:0] w_prod_ext;
    logic [c_SUM_W-1:0] w_psum_ext;
    logic [c_SUM_W-1:0] w_weight_ext;
    logic [c_SUM_W-1:0] w_sum;
    logic               w_sat_en;
    logic               w_ovf;
    logic [ACC_W-1:0]   w_result;

    assign w_prod_ext   = {{(c_SUM_W - c_PROD_W){r_s1_product[c_PROD_W-1]}}, r_s1_product};
    assign w_psum_ext   = {r_s1_psum[ACC_W-1], r_s1_psum};
    assign w_weight_ext = {{(c_SUM_W - DATA_W){r_s1_weight[DATA_W-1]}}, r_s1_weight};

    always_comb begin
        w_sum    = w_psum_ext;
        w_sat_en = 1'b0;
        case (r_s1_mode)
            c_MODE_MAC: begin
                w_sum    = w_psum_ext + w_prod_ext;
                w_sat_en = 1'b1;
            end
            c_MODE_BYP: begin
                w_sum    = w_psum_ext;
            end
            c_MODE_EMIT: begin
                w_sum    = w_weight_ext;
            end
            c_MODE_MUL: begin
                w_sum    = w_prod_ext;
                w_sat_en = 1'b1;
            end
            default: begin
                w_sum    = w_psum_ext;
            end
        endcase
    end

    // The sum is out of ACC_W range exactly when its two top bits differ.
    assign w_ovf    = w_sat_en && (w_sum[ACC_W] != w_sum[ACC_W-1]);
    assign w_result = w_ovf ? (w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX)
                            : w_sum[ACC_W-1:0];

    logic [ACC_W-1:0] r_psum_out;
    logic             r_valid_out;
    logic             r_ovf_out;

    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            r_psum_out  <= '0;
            r_valid_out <= 1'b0;
            r_ovf_out   <= 1'b0;
        end else begin
            r_valid_out <= r_s1_valid;
            if (r_s1_valid) begin
                r_psum_out <= w_result;
                r_ovf_out  <= w_ovf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Feature forwarding runs every cycle, independent of valid
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_feature;
    logic              r_feature_valid;

    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            r_feature       <= '0;
            r_feature_valid <= 1'b0;
        end else begin
            r_feature       <= feature_in;
            r_feature_valid <= valid_in;
        end
    end

    assign feature_out       = r_feature;
    assign feature_valid_out = r_feature_valid;
    assign partial_sum_out   = r_psum_out;
    assign valid_out         = r_valid_out;
    assign ovf_out           = r_ovf_out;

endmodule
`default_nettype wire

// File: tb/tb_pe_ws_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_ws_mac
// Purpose  : Directed self-checking bench for pe_ws_mac. Each sample pushes
//            its expected result to a queue, and results are popped when
//            valid_out rises. Valid timing, feature forwarding and output
//            hold are checked against a small bench-side model every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_ws_mac;

    localparam logic [1:0] c_MAC  = 2'b00;
    localparam logic [1:0] c_BYP  = 2'b01;
    localparam logic [1:0] c_EMIT = 2'b10;
    localparam logic [1:0] c_MUL  = 2'b11;

    logic               clk_in = 1'b0;
    logic               nrst_in;
    logic               weight_load_in;
    logic signed [7:0]  weight_in;
    logic               weight_swap_in;
    logic               valid_in;
    logic [1:0]         mode_in;
    logic signed [7:0]  feature_in;
    logic signed [19:0] partial_sum_in;
    logic signed [7:0]  feature_out;
    logic               feature_valid_out;
    logic signed [19:0] partial_sum_out;
    logic               valid_out;
    logic               ovf_out;

    pe_ws_mac #(.DATA_W(8), .ACC_W(20)) dut (
        .clk_in            (clk_in),
        .nrst_in           (nrst_in),
        .weight_load_in    (weight_load_in),
        .weight_in         (weight_in),
        .weight_swap_in    (weight_swap_in),
        .valid_in          (valid_in),
        .mode_in           (mode_in),
        .feature_in        (feature_in),
        .partial_sum_in    (partial_sum_in),
        .feature_out       (feature_out),
        .feature_valid_out (feature_valid_out),
        .partial_sum_out   (partial_sum_out),
        .valid_out         (valid_out),
        .ovf_out           (ovf_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic signed [19:0] ps;
        logic               ovf;
    } exp_t;

    exp_t               q[$];
    int                 errors = 0;
    int                 checks = 0;
    logic               m_v1 = 1'b0;
    logic               m_v2 = 1'b0;
    logic signed [19:0] last_ps = '0;
    logic               last_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // One rising edge, then check every output against the model.
    task automatic tick();
        logic              rn;
        logic              fv;
        logic signed [7:0] f;
        exp_t              e;
        rn = nrst_in;
        fv = valid_in;
        f  = feature_in;
        @(posedge clk_in);
        #1;
        if (!rn) begin
            m_v1 = 1'b0;
            m_v2 = 1'b0;
            q.delete();
            last_ps  = '0;
            last_ovf = 1'b0;
            f  = '0;
            fv = 1'b0;
        end else begin
            m_v2 = m_v1;
            m_v1 = fv;
        end
        chk("feature_out", feature_out, f);
        chk("feature_valid_out", feature_valid_out, fv);
        chk("valid_out", valid_out, m_v2);
        if (valid_out === 1'b1 && m_v2) begin
            chk("result_available", q.size(), (q.size() > 0) ? q.size() : 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("partial_sum_out", partial_sum_out, e.ps);
                chk("ovf_out", ovf_out, e.ovf);
                last_ps  = e.ps;
                last_ovf = e.ovf;
            end
        end else begin
            chk("psum_hold", partial_sum_out, last_ps);
            chk("ovf_hold", ovf_out, last_ovf);
        end
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_swap(input int w);
        valid_in       = 1'b0;
        weight_load_in = 1'b1;
        weight_in      = w[7:0];
        tick();
        weight_load_in = 1'b0;
        weight_swap_in = 1'b1;
        tick();
        weight_swap_in = 1'b0;
    endtask

    task automatic sample(input logic [1:0] m, input int f, input int ps,
                          input int e_ps, input logic e_ovf);
        exp_t e;
        valid_in       = 1'b1;
        mode_in        = m;
        feature_in     = f[7:0];
        partial_sum_in = ps[19:0];
        e.ps  = e_ps[19:0];
        e.ovf = e_ovf;
        q.push_back(e);
        tick();
        valid_in       = 1'b0;
        weight_load_in = 1'b0;
        weight_swap_in = 1'b0;
    endtask

    initial begin
        // 1. Reset with randomised inputs, then idle
        nrst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            weight_load_in = 1'($urandom);
            weight_swap_in = 1'($urandom);
            weight_in      = 8'($urandom);
            valid_in       = 1'($urandom);
            mode_in        = 2'($urandom);
            feature_in     = 8'($urandom);
            partial_sum_in = 20'($urandom);
            tick();
        end
        weight_load_in = 1'b0;
        weight_swap_in = 1'b0;
        valid_in       = 1'b0;
        nrst_in        = 1'b1;
        idle(5);

        // 2. Basic MAC: 3 * -5 + 100 = 85
        load_swap(3);
        sample(c_MAC, -5, 100, 85, 1'b0);
        idle(3);

        // 3. Saturation both directions
        load_swap(-128);
        sample(c_MAC, -128, 524287, 524287, 1'b1);
        idle(2);
        load_swap(127);
        sample(c_MAC, -128, -524288, -524288, 1'b1);
        idle(3);

        // 4. Double buffer: load 7 while streaming, swap with third sample
        load_swap(2);
        weight_load_in = 1'b1;
        weight_in      = 8'sd7;
        sample(c_MAC, 1, 0, 2, 1'b0);
        sample(c_MAC, 1, 0, 2, 1'b0);
        weight_swap_in = 1'b1;
        sample(c_MAC, 1, 0, 2, 1'b0);
        sample(c_MAC, 1, 0, 7, 1'b0);
        idle(3);

        // 5. Modes back-to-back
        load_swap(4);
        sample(c_MAC,  10, 50, 90, 1'b0);
        sample(c_BYP,  10, 50, 50, 1'b0);
        sample(c_EMIT, 10, 50, 4,  1'b0);
        sample(c_MUL,  10, 50, 40, 1'b0);
        idle(3);

        // 6. Bubble, then reset one cycle after a valid sample
        sample(c_MAC, 1, 0, 4, 1'b0);
        idle(1);
        sample(c_MAC, 2, 0, 8, 1'b0);
        idle(3);
        sample(c_MAC, 3, 0, 12, 1'b0);
        nrst_in = 1'b0;
        tick();
        nrst_in = 1'b1;
        idle(5);

        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
